// File: rtl/warp_dispatcher.sv
// warp_dispatcher: pulls kernels from the warp scheduler into a one-entry
// staging register, starts them on the lowest-index idle SIMD core, tracks
// per-core busy state and reports one retired warp ID per cycle.

package warp_dispatcher_pkg;
    localparam int LOG2_THREAD_COUNT = 4;

    typedef struct packed {
        logic [LOG2_THREAD_COUNT-1:0] thread_count;
        logic [31:0]                  start_pc;
        logic [3:0]                   warp_id;
    } kernel_t;
endpackage

// Per-core tracker: IDLE -> BUSY on start, BUSY -> RETIRE on done,
// RETIRE -> IDLE when the retirement arbiter grants this core.
module warp_core_slot (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       done,
    input  logic       grant,
    input  logic [3:0] warp_id_in,
    output logic       idle,
    output logic       retire,
    output logic [3:0] warp_id
);
    typedef enum logic [1:0] {IDLE, BUSY, RETIRE} state_t;
    state_t state;

    // Core state and the warp ID it is running; done outside BUSY is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            warp_id <= '0;
        end else begin
            case (state)
                IDLE:    if (start) begin
                             state   <= BUSY;
                             warp_id <= warp_id_in;
                         end
                BUSY:    if (done)  state <= RETIRE;
                RETIRE:  if (grant) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign idle   = (state == IDLE);
    assign retire = (state == RETIRE);
endmodule

module warp_dispatcher
    import warp_dispatcher_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int THREADS   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             valid_kernel,
    input  kernel_t                          kernel_in,
    input  logic [NUM_CORES-1:0]             core_done,
    output logic                             launch_kernel,
    output logic [NUM_CORES-1:0]             core_start,
    output logic [31:0]                      core_pc,
    output logic [THREADS-1:0]               core_mask,
    output logic [3:0]                       core_warp_id,
    output logic                             finished_valid,
    output logic [3:0]                       finished_warp_id,
    output logic [$clog2(NUM_CORES+1)-1:0]   busy_cores,
    output logic                             drop
);
    localparam int BW = $clog2(NUM_CORES+1);

    kernel_t                   hold;
    logic                      full;
    logic                      pending;
    logic [NUM_CORES-1:0]      idle, retire;
    logic [NUM_CORES-1:0]      start_sel, grant_sel;
    logic [NUM_CORES-1:0][3:0] slot_id;
    logic [3:0]                grant_id;
    logic                      dispatch, retiring, launch_nxt, accept, bad;
    logic [THREADS-1:0]        mask_nxt;

    // Lowest-index idle core for dispatch, lowest-index retiring core for grant.
    always_comb begin
        start_sel = '0;
        grant_sel = '0;
        grant_id  = 4'hF;
        for (int i = NUM_CORES-1; i >= 0; i--) begin
            if (idle[i]) begin
                start_sel    = '0;
                start_sel[i] = 1'b1;
            end
            if (retire[i]) begin
                grant_sel    = '0;
                grant_sel[i] = 1'b1;
                grant_id     = slot_id[i];
            end
        end
    end

    // Thermometer mask; lanes at or beyond thread_count stay off, which
    // saturates to all-ones once thread_count >= THREADS.
    always_comb begin
        mask_nxt = '0;
        for (int j = 0; j < THREADS; j++)
            mask_nxt[j] = (j < int'(hold.thread_count));
    end

    assign dispatch   = full && (|idle);
    assign retiring   = |retire;
    // Requests only from an empty HOLD; pending blocks the following cycle.
    assign launch_nxt = !full && !pending;
    assign accept     = pending && valid_kernel;
    assign bad        = (kernel_in.thread_count == '0) || (kernel_in.warp_id == 4'hF);

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
        warp_core_slot u_slot (
            .clk        (clk),
            .rst        (rst),
            .start      (start_sel[i] & full),
            .done       (core_done[i]),
            .grant      (grant_sel[i]),
            .warp_id_in (hold.warp_id),
            .idle       (idle[i]),
            .retire     (retire[i]),
            .warp_id    (slot_id[i])
        );
    end

    // Request handshake, staging register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold             <= '0;
            full             <= 1'b0;
            pending          <= 1'b0;
            launch_kernel    <= 1'b0;
            drop             <= 1'b0;
            core_start       <= '0;
            core_pc          <= '0;
            core_mask        <= '0;
            core_warp_id     <= '0;
            finished_valid   <= 1'b0;
            finished_warp_id <= 4'hF;
            busy_cores       <= '0;
        end else begin
            launch_kernel <= launch_nxt;
            pending       <= launch_nxt;
            drop          <= accept && bad;

            // accept implies HOLD empty, dispatch implies HOLD full: exclusive
            if (dispatch)
                full <= 1'b0;
            if (accept && !bad) begin
                hold <= kernel_in;
                full <= 1'b1;
            end

            core_start   <= dispatch ? start_sel     : '0;
            core_pc      <= dispatch ? hold.start_pc : '0;
            core_mask    <= dispatch ? mask_nxt      : '0;
            core_warp_id <= dispatch ? hold.warp_id  : '0;

            finished_valid   <= retiring;
            finished_warp_id <= grant_id;

            busy_cores <= busy_cores + BW'(dispatch) - BW'(retiring);
        end
    end
endmodule

// File: doc/warp_dispatcher.md
# warp_dispatcher

Downstream neighbour of the warp scheduler. It pulls kernels from the scheduler with `launch_kernel`, holds one in a staging register, and dispatches it to the lowest-index idle SIMD core as a start pulse carrying PC, thread mask and warp ID. It tracks each core's busy state, collects completion pulses, and reports one retired warp per cycle on `finished_warp_id` so the scheduler can recycle the ID.

## Interface
- `NUM_CORES`, default 4: number of SIMD cores dispatched to.
- `THREADS`, default 8: lanes per core; width of the thread mask.
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `valid_kernel` input, 1: scheduler's kernel qualifier.
- `kernel_in` input, `kernel_t`: fields `thread_count` [LOG2_THREAD_COUNT], `start_pc` [32], `warp_id` [4].
- `core_done` input, [NUM_CORES]: one-cycle completion pulse per core.
- `launch_kernel` output, 1: request pulse to the scheduler.
- `core_start` output, [NUM_CORES]: one-hot start pulse.
- `core_pc` output, 32: start PC, valid with `core_start`.
- `core_mask` output, [THREADS]: active-lane mask, valid with `core_start`.
- `core_warp_id` output, 4: warp ID, valid with `core_start`.
- `finished_valid` output, 1: retirement qualifier.
- `finished_warp_id` output, 4: retired warp ID; 4'hF when `finished_valid`=0.
- `busy_cores` output, [$clog2(NUM_CORES+1)]: count of cores not IDLE.
- `drop` output, 1: pulse when a received kernel is discarded.

## Operation
- All outputs are registered.
- **Staging register (HOLD).** HOLD has a full flag.
  - `launch_kernel`=1 for exactly one cycle when HOLD is empty and no request is pending. This sets `pending`.
  - `pending` clears on the cycle after `launch_kernel`, whether or not `valid_kernel` was returned. A new request may then issue no earlier than the following cycle, so requests are at most every 2 cycles.
  - `valid_kernel`=1 is accepted only while `pending`=1; otherwise it is ignored.
  - An accepted kernel with `thread_count`=0 or `warp_id`=4'hF is not stored and `drop` pulses for one cycle. Any other accepted kernel loads HOLD and sets full.
- **Dispatch.** When HOLD is full and any core is IDLE:
  - The lowest-index IDLE core i is chosen.
  - `core_start[i]` pulses and `core_pc`/`core_mask`/`core_warp_id` are driven for one cycle.
  - Core i goes to BUSY, its warp ID is latched per-core, and HOLD empties.
  - `core_mask` = (1<<`thread_count`)-1, saturated to all-ones when `thread_count` >= THREADS.
  - When `core_start` is 0, the buses read 0.
- **Per-core FSM:** IDLE -> BUSY (on dispatch) -> RETIRE (on `core_done[i]`) -> IDLE (on the cycle it is granted retirement).
  - `core_done` seen while a core is not BUSY is ignored.
- **Retirement arbiter.** The lowest-index core in RETIRE is granted.
  - `finished_valid`=1 and `finished_warp_id` is that core's latched ID, for one cycle.
  - At most one retirement per cycle; the others wait in RETIRE.
- **Simultaneous events.**
  - Dispatch and retirement in the same cycle are independent.
  - A core granted retirement in cycle t is IDLE from t+1 and dispatchable no earlier than t+1.
  - `core_done[i]` in the same cycle core i's `core_start` is being issued is ignored; core i is not yet BUSY.
- `busy_cores` counts BUSY plus RETIRE cores and updates on the same edge as the FSMs.

## Timing
- **Reset** (asynchronous, takes effect immediately):
  - HOLD is empty, `pending`=0, all cores are IDLE.
  - `launch_kernel`=0, `core_start`=0, buses=0, `finished_valid`=0, `finished_warp_id`=4'hF, `busy_cores`=0, `drop`=0.
  - Reset mid-dispatch discards HOLD and all per-core state. No retirement is reported for warps in flight.
- First `launch_kernel` occurs on the first edge after `rst` deasserts.
- Request to acceptance: `launch_kernel` at edge t; `valid_kernel` is sampled at edge t+1.
- Acceptance to `core_start`: HOLD loads at edge t+1; `core_start` is high in the cycle after edge t+2, if a core is IDLE.
- `core_done[i]` sampled at edge t moves core i to RETIRE. `finished_valid` is high after edge t+1 if core i is the lowest-index core in RETIRE.
- Back-pressure: when all cores are BUSY and HOLD is full, `launch_kernel` stays 0 until HOLD drains.

## Test plan
- **Single kernel:** reset. Return `valid_kernel` one cycle after `launch_kernel` with `thread_count`=3, `start_pc`=32'h100, `warp_id`=2. Expect `core_start`=4'b0001, `core_mask`=8'b00000111, `core_pc`=32'h100, `busy_cores`=1. Pulse `core_done[0]` -> `finished_valid` with ID 2 one cycle later, `busy_cores`=0.
- **Fill all cores:** issue 5 kernels with IDs 0..4. Expect cores 0..3 started in order and ID 4 held in HOLD. `launch_kernel` stays low until `core_done[2]`; after that retirement, ID 4 dispatches to core 2.
- **Simultaneous done:** with cores 0..3 BUSY (IDs 5,6,7,8), pulse `core_done`=4'b1010 in one cycle. Expect ID 6 retired, then ID 8 on the next cycle; `busy_cores` goes 4 -> 3 -> 2.
- **Drops and ignored inputs:**
  - Kernel with `thread_count`=0 -> `drop` pulse, no `core_start`.
  - Kernel with `warp_id`=4'hF -> `drop` pulse.
  - Unrequested `valid_kernel` -> ignored, no `drop`.
  - `core_done[1]` while core 1 is IDLE -> no retirement.
- **Mask saturation and reset mid-operation:**
  - Kernel with `thread_count`=7 -> `core_mask`=8'h7F. With `THREADS`=4, the same kernel -> `core_mask`=4'hF.
  - Assert `rst` asynchronously mid-cycle with 2 cores BUSY -> all outputs at reset values immediately. No `finished_valid` follows, and the first post-reset `launch_kernel` occurs one edge after deassert.
